// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle.
// Groups the instruction-memory read port and the decode-side valid/ready
// handshake that the fetch stage drives.
//   master (fetch stage): drives mem_addr, mem_read, instr_out, instr_pc, instr_valid;
//                         samples mem_data, instr_ready
//   slave  (memory/decode side): the mirror image
interface instruction_fetch_if #(
    parameter int WORD_SIZE   = 15,
    parameter int INSTR_WIDTH = 16
);
    logic [WORD_SIZE-1:0]   mem_addr;
    logic                   mem_read;
    logic [INSTR_WIDTH-1:0] mem_data;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [WORD_SIZE-1:0]   instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;

    modport master (
        output mem_addr,
        output mem_read,
        input  mem_data,
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_read,
        output mem_data,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Sits directly after the program counter: steers the PC through pc_selector,
// strobes a fixed-latency instruction memory at the current PC, captures the
// returned word into an instruction register and offers it to decode with a
// valid/ready handshake. A taken branch flushes the stage and loads the PC.
// Ports:
//   clock, reset    single clock; asynchronous active-high reset
//   pc_in           current PC value
//   pc_selector     to PC: 0 = NEXT, 1 = KEEP, 2 = LOAD (3 never driven)
//   pc_target       PC load value, always branch_target
//   branch_taken    single-cycle redirect request (ignored in IDLE)
//   branch_target   redirect address
//   bus             memory read port + decode handshake (master side)
module instruction_fetch #(
    parameter int WORD_SIZE   = 15,
    parameter int INSTR_WIDTH = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc_in,
    output logic [1:0]           pc_selector,
    output logic [WORD_SIZE-1:0] pc_target,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_target,
    instruction_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NEXT = 2'd0;
    localparam logic [1:0] SEL_KEEP = 2'd1;
    localparam logic [1:0] SEL_LOAD = 2'd2;

    // WAIT spends MEM_LATENCY cycles; the last one (count 0) sees valid mem_data.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [3:0]             count_r;
    logic [3:0]             count_next_s;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic [INSTR_WIDTH-1:0] instr_next_s;
    logic [WORD_SIZE-1:0]   instr_pc_r;
    logic [WORD_SIZE-1:0]   instr_pc_next_s;
    logic                   valid_r;
    logic                   valid_next_s;
    logic [1:0]             selector_s;
    logic                   mem_read_s;

    // State and instruction register update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= 4'd0;
            instr_r    <= '0;
            instr_pc_r <= '0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            count_r    <= count_next_s;
            instr_r    <= instr_next_s;
            instr_pc_r <= instr_pc_next_s;
            valid_r    <= valid_next_s;
        end
    end

    // Next-state, capture and PC-steering decode.
    always_comb begin
        state_next_s    = state_r;
        count_next_s    = count_r;
        instr_next_s    = instr_r;
        instr_pc_next_s = instr_pc_r;
        valid_next_s    = valid_r;
        selector_s      = SEL_KEEP;
        mem_read_s      = 1'b0;

        case (state_r)
            // Give the PC one cycle out of reset before the first read.
            ST_IDLE: begin
                state_next_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                mem_read_s   = 1'b1;
                count_next_s = WAIT_LOAD;
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_r != 4'd0) begin
                    count_next_s = count_r - 4'd1;
                end else begin
                    // pc_in still holds the fetched address on this edge;
                    // the PC advances on the same edge.
                    instr_next_s    = bus.mem_data;
                    instr_pc_next_s = pc_in;
                    valid_next_s    = 1'b1;
                    selector_s      = SEL_NEXT;
                    state_next_s    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    valid_next_s = 1'b0;
                    state_next_s = ST_ISSUE;
                end else begin
                    valid_next_s = 1'b1;
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Redirect wins over capture and handshake; in-flight or held data is
        // dropped. The ISSUE read strobe is left alone (its data never lands).
        if (branch_taken && (state_r != ST_IDLE)) begin
            selector_s      = SEL_LOAD;
            state_next_s    = ST_ISSUE;
            valid_next_s    = 1'b0;
            count_next_s    = 4'd0;
            instr_next_s    = instr_r;
            instr_pc_next_s = instr_pc_r;
        end else begin
            selector_s = selector_s;
        end
    end

    assign pc_selector     = selector_s;
    assign pc_target       = branch_target;
    assign bus.mem_addr    = pc_in;
    assign bus.mem_read    = mem_read_s;
    assign bus.instr_out   = instr_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.instr_valid = valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Two instances: one with a 1-cycle
// memory, one with a 3-cycle memory, each with its own PC and memory model.
module tb_instruction_fetch;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    // Memory contents: address 0 holds 16'h1234, everything else addr ^ 16'h5A00.
    function automatic logic [15:0] memword(input logic [14:0] a);
        if (a == 15'd0) return 16'h1234;
        else return {1'b0, a} ^ 16'h5A00;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- instance A: MEM_LATENCY = 1 ----------------
    logic        rst_a = 1'b0;
    logic        ready_a = 1'b1;
    logic [14:0] pc_a;
    logic [1:0]  sel_a;
    logic [14:0] tgt_a;
    logic [15:0] mdat_a;
    instruction_fetch_if #(.WORD_SIZE(15), .INSTR_WIDTH(16)) bus_a ();

    instruction_fetch #(.WORD_SIZE(15), .INSTR_WIDTH(16), .MEM_LATENCY(1)) dut_a (
        .clock(clock), .reset(rst_a), .pc_in(pc_a), .pc_selector(sel_a),
        .pc_target(tgt_a), .branch_taken(1'b0), .branch_target(15'h0000),
        .bus(bus_a.master)
    );

    always_ff @(posedge clock or posedge rst_a) begin
        if (rst_a) pc_a <= 15'd0;
        else if (sel_a == 2'd0) pc_a <= pc_a + 15'd1;
        else if (sel_a == 2'd2) pc_a <= tgt_a;
        else pc_a <= pc_a;
    end

    always_ff @(posedge clock) begin
        mdat_a <= bus_a.mem_read ? memword(bus_a.mem_addr) : 16'hDEAD;
    end
    assign bus_a.mem_data    = mdat_a;
    assign bus_a.instr_ready = ready_a;

    // ---------------- instance B: MEM_LATENCY = 3 ----------------
    logic        rst_b = 1'b0;
    logic        ready_b = 1'b0;
    logic        br_b = 1'b0;
    logic [14:0] brt_b = 15'd0;
    logic [14:0] pc_b;
    logic [1:0]  sel_b;
    logic [14:0] tgt_b;
    logic [15:0] p0_b, p1_b, p2_b;
    instruction_fetch_if #(.WORD_SIZE(15), .INSTR_WIDTH(16)) bus_b ();

    instruction_fetch #(.WORD_SIZE(15), .INSTR_WIDTH(16), .MEM_LATENCY(3)) dut_b (
        .clock(clock), .reset(rst_b), .pc_in(pc_b), .pc_selector(sel_b),
        .pc_target(tgt_b), .branch_taken(br_b), .branch_target(brt_b),
        .bus(bus_b.master)
    );

    always_ff @(posedge clock or posedge rst_b) begin
        if (rst_b) pc_b <= 15'd0;
        else if (sel_b == 2'd0) pc_b <= pc_b + 15'd1;
        else if (sel_b == 2'd2) pc_b <= tgt_b;
        else pc_b <= pc_b;
    end

    always_ff @(posedge clock) begin
        p0_b <= bus_b.mem_read ? memword(bus_b.mem_addr) : 16'hDEAD;
        p1_b <= p0_b;
        p2_b <= p1_b;
    end
    assign bus_b.mem_data    = p2_b;
    assign bus_b.instr_ready = ready_b;

    // Ticks until instance B presents an instruction; returns the cycles taken.
    task automatic wait_valid_b(output int n);
        n = 0;
        while (!bus_b.instr_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check_eq("rst_mem_read", {31'd0, bus_a.mem_read}, 32'd0);
        check_eq("rst_selector", {30'd0, sel_a}, 32'd1);
        check_eq("rst_valid", {31'd0, bus_a.instr_valid}, 32'd0);
        check_eq("rst_instr", {16'd0, bus_a.instr_out}, 32'd0);
        check_eq("rst_instr_pc", {17'd0, bus_a.instr_pc}, 32'd0);
        tick();
        tick();

        // Test 1: latency 1 basic fetch of address 0.
        rst_a = 1'b0;
        tick();
        check_eq("t1_issue_read", {31'd0, bus_a.mem_read}, 32'd1);
        check_eq("t1_issue_addr", {17'd0, bus_a.mem_addr}, 32'd0);
        check_eq("t1_issue_sel", {30'd0, sel_a}, 32'd1);
        tick();
        check_eq("t1_wait_sel", {30'd0, sel_a}, 32'd0);
        check_eq("t1_wait_valid", {31'd0, bus_a.instr_valid}, 32'd0);
        tick();
        check_eq("t1_valid", {31'd0, bus_a.instr_valid}, 32'd1);
        check_eq("t1_instr", {16'd0, bus_a.instr_out}, 32'h1234);
        check_eq("t1_instr_pc", {17'd0, bus_a.instr_pc}, 32'd0);
        check_eq("t1_hold_sel", {30'd0, sel_a}, 32'd1);
        tick();
        check_eq("t1_accepted", {31'd0, bus_a.instr_valid}, 32'd0);
        check_eq("t1_next_addr", {17'd0, bus_a.mem_addr}, 32'd1);
        check_eq("t1_next_read", {31'd0, bus_a.mem_read}, 32'd1);
        rst_a = 1'b1;

        // Test 2: latency 3, decode stalls for 10 cycles.
        rst_b = 1'b0;
        tick();
        check_eq("t2_issue_read", {31'd0, bus_b.mem_read}, 32'd1);
        tick();
        tick();
        check_eq("t2_wait_sel", {30'd0, sel_b}, 32'd1);
        tick();
        check_eq("t2_last_wait_sel", {30'd0, sel_b}, 32'd0);
        check_eq("t2_last_wait_valid", {31'd0, bus_b.instr_valid}, 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("t2_hold_valid", {31'd0, bus_b.instr_valid}, 32'd1);
            check_eq("t2_hold_instr", {16'd0, bus_b.instr_out}, 32'h1234);
            check_eq("t2_hold_sel", {30'd0, sel_b}, 32'd1);
            tick();
        end
        ready_b = 1'b1;
        #1;
        check_eq("t2_accept_valid", {31'd0, bus_b.instr_valid}, 32'd1);
        tick();
        ready_b = 1'b0;
        check_eq("t2_after_accept", {31'd0, bus_b.instr_valid}, 32'd0);
        check_eq("t2_next_addr", {17'd0, bus_b.mem_addr}, 32'd1);
        check_eq("t2_next_read", {31'd0, bus_b.mem_read}, 32'd1);
        wait_valid_b(n);
        check_eq("t2_latency", n, 32'd4);
        check_eq("t2_instr", {16'd0, bus_b.instr_out}, 32'h5A01);
        check_eq("t2_instr_pc", {17'd0, bus_b.instr_pc}, 32'd1);

        // Test 3: branch during WAIT to 15'h0040.
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        check_eq("t3_issue_addr", {17'd0, bus_b.mem_addr}, 32'd2);
        tick();
        br_b  = 1'b1;
        brt_b = 15'h0040;
        #1;
        check_eq("t3_branch_sel", {30'd0, sel_b}, 32'd2);
        check_eq("t3_pc_target", {17'd0, tgt_b}, 32'h0040);
        tick();
        br_b = 1'b0;
        check_eq("t3_flushed", {31'd0, bus_b.instr_valid}, 32'd0);
        check_eq("t3_reissue_addr", {17'd0, bus_b.mem_addr}, 32'h0040);
        check_eq("t3_reissue_read", {31'd0, bus_b.mem_read}, 32'd1);
        wait_valid_b(n);
        check_eq("t3_latency", n, 32'd4);
        check_eq("t3_instr", {16'd0, bus_b.instr_out}, 32'h5A40);
        check_eq("t3_instr_pc", {17'd0, bus_b.instr_pc}, 32'h0040);

        // Test 4: branch together with ready in HOLD, target 15'h7FFF.
        ready_b = 1'b1;
        br_b    = 1'b1;
        brt_b   = 15'h7FFF;
        #1;
        check_eq("t4_branch_sel", {30'd0, sel_b}, 32'd2);
        tick();
        ready_b = 1'b0;
        br_b    = 1'b0;
        check_eq("t4_dropped", {31'd0, bus_b.instr_valid}, 32'd0);
        check_eq("t4_reissue_addr", {17'd0, bus_b.mem_addr}, 32'h7FFF);
        check_eq("t4_reissue_read", {31'd0, bus_b.mem_read}, 32'd1);
        wait_valid_b(n);
        check_eq("t4_latency", n, 32'd4);
        check_eq("t6_instr", {16'd0, bus_b.instr_out}, 32'h25FF);
        check_eq("t6_instr_pc", {17'd0, bus_b.instr_pc}, 32'h7FFF);

        // Test 6: after 15'h7FFF the next fetch uses address 0.
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        check_eq("t6_wrap_addr", {17'd0, bus_b.mem_addr}, 32'd0);
        check_eq("t6_wrap_read", {31'd0, bus_b.mem_read}, 32'd1);
        tick();
        tick();
        tick();
        check_eq("t5_pre_sel", {30'd0, sel_b}, 32'd0);

        // Test 5: async reset between edges in the last WAIT cycle.
        #2;
        rst_b = 1'b1;
        #1;
        check_eq("t5_rst_sel", {30'd0, sel_b}, 32'd1);
        check_eq("t5_rst_read", {31'd0, bus_b.mem_read}, 32'd0);
        check_eq("t5_rst_valid", {31'd0, bus_b.instr_valid}, 32'd0);
        check_eq("t5_rst_instr", {16'd0, bus_b.instr_out}, 32'd0);
        check_eq("t5_rst_instr_pc", {17'd0, bus_b.instr_pc}, 32'd0);
        tick();
        tick();
        check_eq("t5_held_valid", {31'd0, bus_b.instr_valid}, 32'd0);
        rst_b = 1'b0;
        wait_valid_b(n);
        check_eq("t5_refetch_latency", n, 32'd5);
        check_eq("t5_instr", {16'd0, bus_b.instr_out}, 32'h1234);
        check_eq("t5_instr_pc", {17'd0, bus_b.instr_pc}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
